// File: rtl/fir_frame_buffer.sv
// rtl/fir_frame_buffer.sv - FIR output decimator/scaler feeding a ping-pong chirp-frame buffer
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fir_data, valid         signed FIR samples, one per asserted valid
//   frame_start             chirp start; restarts decimation phase and frame capture
//   out_valid, out_ready    frame stream handshake toward the range FFT
//   out_data                signed scaled sample (OUT_WIDTH)
//   out_index, out_last     sample index within frame; last marks FRAME_LEN-1
//   ovf_clr, overflow       sticky drop flag and its clear
//
// Build option: FIR_FRAME_ROUND_EN selects round-half-up scaling; default is floor.

module fir_frame_buffer #(
    parameter int IN_WIDTH  = 28,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 12,
    parameter int DECIM     = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  fir_data,
    input  logic                 valid,
    input  logic                 frame_start,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]    out_index,
    output logic                 out_last,
    input  logic                 ovf_clr,
    output logic                 overflow
);

    localparam int FRAME_LEN = 2 ** ADDR_W;
    localparam int PH_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SW        = IN_WIDTH + 1;

    localparam logic [ADDR_W-1:0] LAST_IDX       = {ADDR_W{1'b1}};
    localparam logic [PH_W-1:0]   PH_LAST        = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0]   PH_AFTER_START = (DECIM > 1) ? PH_W'(1) : '0;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef FIR_FRAME_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(1) << (SHIFT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2
    } rd_state_t;

    // capture side
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                 wr_bank_q, wr_bank_d;
    // one-cycle write pipeline into the RAM
    logic                 wr_en_q, wr_en_d;
    logic                 wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [OUT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                 wr_done_q, wr_done_d;
    // bank status
    logic [1:0]           full_q, full_d;
    logic                 overflow_q, overflow_d;
    // read side
    rd_state_t            state_q, state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0]    out_index_q, out_index_d;
    logic                 out_last_q, out_last_d;

    logic [OUT_WIDTH-1:0] mem [0:2*FRAME_LEN-1];
    logic [ADDR_W-1:0]    rd_addr;
    logic [OUT_WIDTH-1:0] rd_word;

    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;
    logic [OUT_WIDTH-1:0] scaled;

    logic                 keep;
    logic                 drop;
    logic                 free;
    logic                 bank_busy;
    logic [ADDR_W-1:0]    ptr_base;

    // Scaling is done in IN_WIDTH+1 bits so the rounding bias cannot wrap.
    always_comb begin
        ext = $signed({fir_data[IN_WIDTH-1], fir_data});
`ifdef FIR_FRAME_ROUND_EN
        biased = ext + $signed(RND);
`else
        biased = ext;
`endif
        shifted = biased >>> SHIFT;
        if (shifted > SAT_MAX) begin
            scaled = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            scaled = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            scaled = shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            mem[{wr_sel_q, wr_addr_q}] <= wr_data_q;
        end
    end

    // STREAM prefetches the next word so a handshake can advance every cycle.
    always_comb begin
        rd_addr = '0;
        if (state_q == S_STREAM) begin
            rd_addr = out_index_q + ADDR_W'(1);
        end
    end

    assign rd_word = mem[{rd_bank_q, rd_addr}];

    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        free        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                out_data_d  = rd_word;
                out_index_d = '0;
                out_last_d  = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        free        = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rd_bank_d   = ~rd_bank_q;
                        state_d     = S_IDLE;
                    end else begin
                        out_data_d  = rd_word;
                        out_index_d = out_index_q + ADDR_W'(1);
                        out_last_d  = ((out_index_q + ADDR_W'(1)) == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Banks fill strictly alternately, so the read bank simply toggles per frame.
    always_comb begin
        phase_d   = phase_q;
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_done_d = 1'b0;
        drop      = 1'b0;

        if (frame_start) begin
            phase_d = valid ? PH_AFTER_START : '0;
        end else if (valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        keep      = valid && (frame_start || (phase_q == '0));
        ptr_base  = frame_start ? '0 : wr_ptr_q;
        // A bank released this very cycle is writable again.
        bank_busy = full_q[wr_bank_q] && !(free && (rd_bank_q == wr_bank_q));

        if (frame_start) begin
            wr_ptr_d = '0;
        end

        if (keep) begin
            if (bank_busy) begin
                drop     = 1'b1;
                wr_ptr_d = ptr_base;
            end else begin
                wr_en_d   = 1'b1;
                wr_sel_d  = wr_bank_q;
                wr_addr_d = ptr_base;
                wr_data_d = scaled;
                if (ptr_base == LAST_IDX) begin
                    wr_done_d = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    wr_ptr_d  = '0;
                end else begin
                    wr_ptr_d = ptr_base + ADDR_W'(1);
                end
            end
        end

        full_d = full_q;
        if (free) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_en_q && wr_done_q) begin
            full_d[wr_sel_q] = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_done_q   <= 1'b0;
            full_q      <= 2'b00;
            overflow_q  <= 1'b0;
            state_q     <= S_IDLE;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_done_q   <= wr_done_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_frame_buffer.sv
// tb/tb_fir_frame_buffer.sv - directed self-checking bench for fir_frame_buffer

module tb_fir_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] fir_data = '0;
    logic        valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_data[$];
    logic [3:0]  q_idx[$];
    logic        q_last[$];

    fir_frame_buffer #(
        .IN_WIDTH (28),
        .OUT_WIDTH(16),
        .SHIFT    (12),
        .DECIM    (4),
        .ADDR_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fir_data   (fir_data),
        .valid      (valid),
        .frame_start(frame_start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so the negedge view is what the next edge accepts.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_idx.push_back(out_index);
            q_last.push_back(out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [27:0] v);
        valid    = 1'b1;
        fir_data = v;
        tick();
    endtask

    task automatic clear_q();
        q_data.delete();
        q_idx.delete();
        q_last.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0000", out_data); end
        n_checks++; if (out_index !== 4'h0) begin n_fail++; $display("FAIL rst_out_index: got %h expected 0", out_index); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_ramp();
        out_ready = 1'b1;
        clear_q();
        for (int n = 0; n < 64; n++) begin
            push(28'(n << 12));
            if (n == 62) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_early_valid: got %b expected 0", out_valid); end
            end
        end
        valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_latency: got %b expected 1", out_valid); end
        repeat (15) tick();
        n_checks++; if (out_valid !== 1'b1 || out_index !== 4'd15 || out_last !== 1'b1) begin
            n_fail++; $display("FAIL ramp_last_beat: got v=%b idx=%0d last=%b expected v=1 idx=15 last=1", out_valid, out_index, out_last);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_end_valid: got %b expected 0", out_valid); end
        n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL ramp_count: got %0d expected 16", q_data.size()); end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'(4 * i) || q_idx[i] !== 4'(i) || q_last[i] !== (i == 15)) begin
                n_fail++; $display("FAIL ramp_beat%0d: got d=%0d idx=%0d last=%b expected d=%0d idx=%0d last=%b",
                                   i, q_data[i], q_idx[i], q_last[i], 4 * i, i, (i == 15));
            end
        end
    endtask

    task automatic test_saturation();
        logic [27:0] sv[16];
        logic [15:0] ev[16];
        for (int i = 0; i < 16; i++) begin
            sv[i] = 28'(i << 12);
            ev[i] = 16'(i);
        end
        sv[0] = 28'h7FFFFFF; ev[0] = 16'h7FFF;
        sv[1] = 28'h8000000; ev[1] = 16'h8000;
        sv[2] = 28'h0000800;
        sv[3] = 28'hFFFF800;
        sv[4] = 28'hFFFB000; ev[4] = 16'hFFFB;
        sv[5] = 28'h7FFF800; ev[5] = 16'h7FFF;
`ifdef FIR_FRAME_ROUND_EN
        ev[2] = 16'h0001;
        ev[3] = 16'h0000;
`else
        ev[2] = 16'h0000;
        ev[3] = 16'hFFFF;
`endif
        out_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 16; i++) begin
            push(sv[i]);
            repeat (3) push(28'h1234567);
        end
        valid = 1'b0;
        repeat (20) tick();
        n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL sat_count: got %0d expected 16", q_data.size()); end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== ev[i] || q_idx[i] !== 4'(i)) begin
                n_fail++; $display("FAIL sat_beat%0d: got d=%h idx=%0d expected d=%h idx=%0d", i, q_data[i], q_idx[i], ev[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        out_ready = 1'b1;
        clear_q();
        for (int n = 0; n < 64; n++) push(28'(n << 12));
        valid = 1'b0;
        c = 0;
        while (!(out_valid === 1'b1 && out_index === 4'd7) && c < 50) begin
            tick();
            c++;
        end
        n_checks++; if (c >= 50) begin n_fail++; $display("FAIL bp_reach_idx7: got timeout expected index 7"); end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 4'd7 || out_data !== 16'd28 || out_last !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b idx=%0d d=%0d last=%b expected v=1 idx=7 d=28 last=0",
                                   k, out_valid, out_index, out_data, out_last);
            end
        end
        out_ready = 1'b1;
        repeat (20) tick();
        n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d expected 16", q_data.size()); end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'(4 * i) || q_idx[i] !== 4'(i)) begin
                n_fail++; $display("FAIL bp_beat%0d: got d=%0d idx=%0d expected d=%0d idx=%0d", i, q_data[i], q_idx[i], 4 * i, i);
            end
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        clear_q();
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 64; n++) push(28'((f * 64 + n) << 12));
        end
        valid = 1'b0;
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", overflow); end
        for (int n = 0; n < 64; n++) begin
            ovf_clr = (n == 4 || n == 5);
            push(28'((128 + n) << 12));
            ovf_clr = 1'b0;
            if (n == 0) begin
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_first_drop: got %b expected 1", overflow); end
            end
            if (n == 4) begin
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_beats_clr: got %b expected 1", overflow); end
            end
            if (n == 5) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_mid: got %b expected 0", overflow); end
            end
            if (n == 8) begin
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_reset_again: got %b expected 1", overflow); end
            end
        end
        valid = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_end: got %b expected 0", overflow); end
        out_ready = 1'b1;
        repeat (45) tick();
        n_checks++; if (q_data.size() != 32) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 32", q_data.size()); end
        for (int i = 0; i < 32 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'((i / 16) * 64 + 4 * (i % 16)) || q_idx[i] !== 4'(i % 16)) begin
                n_fail++; $display("FAIL ovf_beat%0d: got d=%0d idx=%0d expected d=%0d idx=%0d",
                                   i, q_data[i], q_idx[i], (i / 16) * 64 + 4 * (i % 16), i % 16);
            end
        end
    endtask

    task automatic test_frame_start();
        out_ready = 1'b1;
        clear_q();
        for (int n = 0; n < 18; n++) push(28'((100 + n) << 12));
        for (int m = 0; m < 64; m++) begin
            frame_start = (m == 0);
            push(28'((200 + m) << 12));
            frame_start = 1'b0;
        end
        valid = 1'b0;
        repeat (20) tick();
        n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL fs_count: got %0d expected 16", q_data.size()); end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'(200 + 4 * i) || q_idx[i] !== 4'(i)) begin
                n_fail++; $display("FAIL fs_beat%0d: got d=%0d idx=%0d expected d=%0d idx=%0d", i, q_data[i], q_idx[i], 200 + 4 * i, i);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        int c;
        int vcount;
        out_ready = 1'b0;
        clear_q();
        for (int n = 0; n < 64; n++) push(28'((300 + n) << 12));
        valid = 1'b0;
        c = 0;
        while (out_valid !== 1'b1 && c < 10) begin
            tick();
            c++;
        end
        n_checks++; if (c >= 10) begin n_fail++; $display("FAIL rms_wait_valid: got timeout expected out_valid"); end
        out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_index !== 4'h0 || out_last !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rms_async_clear: got v=%b d=%h idx=%0d last=%b ovf=%b expected all 0",
                               out_valid, out_data, out_index, out_last, overflow);
        end
        tick();
        tick();
        rst_n = 1'b1;
        clear_q();
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid === 1'b1) vcount++;
        end
        n_checks++; if (vcount != 0) begin n_fail++; $display("FAIL rms_no_stale_frame: got %0d valid cycles expected 0", vcount); end
        for (int n = 0; n < 64; n++) push(28'((400 + n) << 12));
        valid = 1'b0;
        repeat (20) tick();
        n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL rms_count: got %0d expected 16", q_data.size()); end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'(400 + 4 * i) || q_idx[i] !== 4'(i)) begin
                n_fail++; $display("FAIL rms_beat%0d: got d=%0d idx=%0d expected d=%0d idx=%0d", i, q_data[i], q_idx[i], 400 + 4 * i, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_backpressure();
        test_overflow();
        test_frame_start();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
